// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared constants for the execute-stage ALU: 4-bit op codes
//               (common with the ALU control decoder), FSM state encoding
//               and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_SHAMT_W = 5;

    // ALU control codes
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_SLL = 4'b1001;
    localparam logic [3:0] c_ALU_SRL = 4'b1010;
    localparam logic [3:0] c_ALU_XOR = 4'b1011;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;

    // Execute FSM states
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_SHIFT    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_OUT = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == c_ALU_SLL) || (op == c_ALU_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_shifter
// Description : Iterative logical shifter, one bit position per cycle.
//               i_load captures data, direction (0=left, 1=right) and count;
//               o_busy is high while shifting; o_done marks the cycle doing
//               the final shift; o_data is the working register.
// Ports       : clk, rst (sync, active-high), i_load, i_dir, i_count,
//               i_data, o_busy, o_done, o_data
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_shifter
    import alu_exec_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int SHAMT_W = c_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_dir,
    input  logic [SHAMT_W-1:0] i_count,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_data
);

    logic [SHAMT_W-1:0] r_count;
    logic               r_dir;
    logic [DATA_W-1:0]  r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_dir   <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_count <= i_count;
            r_dir   <= i_dir;
            r_data  <= i_data;
        end else if (r_count != '0) begin
            // zero fill in both directions (logical shift)
            r_data  <= r_dir ? {1'b0, r_data[DATA_W-1:1]}
                             : {r_data[DATA_W-2:0], 1'b0};
            r_count <= r_count - SHAMT_W'(1);
        end
    end

    assign o_busy = (r_count != '0);
    assign o_done = (r_count == SHAMT_W'(1));
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshakes. Logic and
//               arithmetic ops finish in one cycle; SLL/SRL use an iterative
//               shifter unless BARREL_SHIFT_EN is defined, in which case a
//               combinational barrel shifter makes them single-cycle too.
// Ports       : clk, reset (sync, active-high), in_valid/in_ready,
//               alu_control[3:0], operand_a, operand_b, shamt,
//               out_valid/out_ready, result, zero, overflow
// Macro       : BARREL_SHIFT_EN - select combinational shifting
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int SHAMT_W = c_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [DATA_W-1:0]  operand_a,
    input  logic [DATA_W-1:0]  operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               overflow
);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_overflow;
    logic              r_out_valid;

    logic              w_out_free;
    logic              w_accept;
    logic              w_multi;
    logic              w_sh_busy;
    logic              w_sh_done;
    logic [DATA_W-1:0] w_sh_data;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_ovf;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == c_ST_IDLE) && !w_sh_busy && w_out_free;
    assign w_accept   = in_valid && in_ready;

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (alu_control)
            c_ALU_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                            (w_sum[DATA_W-1] != operand_a[DATA_W-1]);
            end
            c_ALU_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                            (w_diff[DATA_W-1] != operand_a[DATA_W-1]);
            end
            c_ALU_AND: w_alu_res = operand_a & operand_b;
            c_ALU_OR:  w_alu_res = operand_a | operand_b;
            c_ALU_NOR: w_alu_res = ~(operand_a | operand_b);
            c_ALU_XOR: w_alu_res = operand_a ^ operand_b;
            // direct signed compare, immune to subtraction overflow
            c_ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}},
                                    ($signed(operand_a) < $signed(operand_b))};
`ifdef BARREL_SHIFT_EN
            c_ALU_SLL: w_alu_res = operand_b << shamt;
            c_ALU_SRL: w_alu_res = operand_b >> shamt;
`else
            // only reaches the output register when shamt == 0
            c_ALU_SLL: w_alu_res = operand_b;
            c_ALU_SRL: w_alu_res = operand_b;
`endif
            default:   w_alu_res = '0;
        endcase
    end

`ifdef BARREL_SHIFT_EN
    assign w_multi   = 1'b0;
    assign w_sh_busy = 1'b0;
    assign w_sh_done = 1'b0;
    assign w_sh_data = '0;
`else
    logic w_sh_load;

    assign w_multi   = is_shift_op(alu_control) && (shamt != '0);
    assign w_sh_load = w_accept && w_multi;

    alu_serial_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_sh_load),
        .i_dir   (alu_control == c_ALU_SRL),
        .i_count (shamt),
        .i_data  (operand_b),
        .o_busy  (w_sh_busy),
        .o_done  (w_sh_done),
        .o_data  (w_sh_data)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_state <= c_ST_SHIFT;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_overflow  <= w_alu_ovf;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    if (w_sh_done) begin
                        r_state <= c_ST_WAIT_OUT;
                    end
                end
                c_ST_WAIT_OUT: begin
                    if (w_out_free) begin
                        r_result    <= w_sh_data;
                        r_zero      <= (w_sh_data == '0);
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Scoreboard bench for alu_exec_unit. Stimulus pushes the
//               hand-computed expected response (and expected first-valid
//               cycle) into a queue; a monitor pops and compares whenever
//               the DUT presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam logic [3:0] c_AND = 4'b0000, c_OR  = 4'b0001, c_ADD = 4'b0010,
                           c_SUB = 4'b0110, c_SLT = 4'b0111, c_SLL = 4'b1001,
                           c_SRL = 4'b1010, c_XOR = 4'b1011, c_NOR = 4'b1100,
                           c_BAD = 4'b1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        int          exp_cyc;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_n    = 0;
    bit   presented = 0;
    bit   blk_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller must be positioned just after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] er, input logic ez,
                         input logic eo, input int lat, input bit push);
        int   t;
        exp_t e;
        in_valid    = 1'b1;
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        shamt       = sh;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: op %b never accepted", op);
                in_valid = 1'b0;
                return;
            end
        end
        if (push) begin
            e.res     = er;
            e.z       = ez;
            e.ov      = eo;
            e.exp_cyc = (lat >= 0) ? cyc + lat : -1;
            e.tag     = tag_n;
            sb_q.push_back(e);
        end
        tag_n++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    // Monitor / scoreboard checker
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                presented = 0;
            end else if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got 0x%08h with no pending op", result);
                end else begin
                    e = sb_q[0];
                    if (!presented) begin
                        presented = 1;
                        if (e.exp_cyc >= 0)
                            chk($sformatf("latency_op%0d", e.tag), cyc, e.exp_cyc);
                    end
                    chk($sformatf("result_op%0d", e.tag), result, e.res);
                    chk($sformatf("zero_op%0d", e.tag), {31'b0, zero}, {31'b0, e.z});
                    chk($sformatf("overflow_op%0d", e.tag), {31'b0, overflow}, {31'b0, e.ov});
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        presented = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", {31'b0, zero}, 32'd0);
        chk("reset_overflow", {31'b0, overflow}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single-cycle ops
        issue(c_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1, 1);
        issue(c_SUB, 32'd5,         32'd5,         5'd0, 32'h0000_0000, 1'b1, 1'b0, 1, 1);
        issue(c_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1);
        issue(c_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1, 1);
        issue(c_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1, 1);
        issue(c_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1, 1);
        issue(c_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1, 1);
        issue(c_OR,  32'h1234_0000, 32'h0000_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1, 1);
        issue(c_NOR, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1);
        issue(c_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 32'h5A5A_A5A5, 1'b0, 1'b0, 1, 1);
        issue(c_BAD, 32'h0000_0005, 32'h0000_0003, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1, 1);
        issue(c_SRL, 32'h0000_0000, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1, 1);
        drain();

        // Iterative shift by 31: result at T+33, in_ready low meanwhile
        issue(c_SLL, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 33, 1);
        blk_bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (in_ready) blk_bad = 1;
        end
        chk("in_ready_low_during_shift", {31'b0, blk_bad}, 32'd0);
        drain();

        // Backpressure: AND held, SRL waits for the output slot
        out_ready = 1'b0;
        issue(c_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 1'b0, 1, 1);
        blk_bad = 0;
        fork
            issue(c_SRL, 32'h0, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0, 1'b0, 6, 1);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (in_ready) blk_bad = 1;
                end
                chk("in_ready_low_when_blocked", {31'b0, blk_bad}, 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back stream of ADDs
        for (int i = 0; i < 8; i++) begin
            issue(c_ADD, 32'(i), 32'h0000_0010, 5'd0, 32'h10 + 32'(i), 1'b0, 1'b0, 1, 1);
        end
        drain();

        // Reset in the middle of SLL by 20 aborts it
        issue(c_SLL, 32'h0, 32'h0000_0001, 5'd20, 32'h0, 1'b0, 1'b0, -1, 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (30) @(negedge clk);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
